// File: rtl/upload_scheduler.sv
// ---------------------------------------------------------------------------
// upload_scheduler
//   Tracks rotor position from the encoder and schedules uploads to the LED
//   shifter. Each slice boundary requests a grayscale upload of that slice.
//   A control upload is requested after reset, on the home index, after
//   every CTRL_REFRESH grayscale uploads, and after a shifter timeout.
//
// Ports
//   CLK_10M       in   sole clock, rising edge
//   nReset        in   asynchronous active-low reset
//   ENC_ABS_HOME  in   asynchronous encoder home index
//   ENC_360       in   asynchronous encoder pulse train
//   enable        in   permits new uploads to start
//   shift_done    in   one-cycle completion pulse from the shifter
//   clr_flags     in   clears overrun and timeout
//   shift_start   out  one-cycle upload request
//   shift_sel     out  0 = grayscale, 1 = control (held during the upload)
//   shift_slice   out  slice to upload (held during the upload)
//   slice_idx     out  current rotor slice
//   busy          out  waiting for the shifter
//   overrun       out  sticky: a pending slice was replaced before upload
//   timeout       out  sticky: shift_done did not arrive in time
// ---------------------------------------------------------------------------
module upload_scheduler #(
    parameter int SLICES       = 30,
    parameter int SLICE_DIV    = 12,
    parameter int CTRL_REFRESH = 10,
    parameter int TIMEOUT      = 4096
) (
    input  logic       CLK_10M,
    input  logic       nReset,
    input  logic       ENC_ABS_HOME,
    input  logic       ENC_360,
    input  logic       enable,
    input  logic       shift_done,
    input  logic       clr_flags,
    output logic       shift_start,
    output logic       shift_sel,
    output logic [7:0] shift_slice,
    output logic [7:0] slice_idx,
    output logic       busy,
    output logic       overrun,
    output logic       timeout
);

    localparam int EW = (SLICE_DIV > 1) ? $clog2(SLICE_DIV) : 1;
    localparam int GW = $clog2(CTRL_REFRESH + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CTRL_REQ,
        CTRL_WAIT,
        GS_REQ,
        GS_WAIT
    } state_t;

    state_t state_q, state_d;

    // Synchronizers: [0],[1] resynchronise, [2] holds the previous value
    // for edge detection; the tick itself is registered.
    logic [2:0] home_sync_q, enc_sync_q;
    logic       home_tick_q, enc_tick_q;

    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic [7:0]    slice_idx_q, slice_idx_d;
    logic          slice_pend_q, slice_pend_d;
    logic [7:0]    pend_idx_q, pend_idx_d;
    logic          ctrl_pend_q, ctrl_pend_d;
    logic [GW-1:0] gs_cnt_q, gs_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;

    logic          shift_start_q, shift_start_d;
    logic          shift_sel_q, shift_sel_d;
    logic [7:0]    shift_slice_q, shift_slice_d;

    logic       home_ev, enc_ev, boundary, slice_ev;
    logic       in_wait, in_req, wait_done, wait_expire;
    logic [7:0] next_idx;

    always_ff @(posedge CLK_10M or negedge nReset) begin
        if (!nReset) begin
            home_sync_q <= '0;
            enc_sync_q  <= '0;
            home_tick_q <= 1'b0;
            enc_tick_q  <= 1'b0;
        end else begin
            home_sync_q <= {home_sync_q[1:0], ENC_ABS_HOME};
            enc_sync_q  <= {enc_sync_q[1:0], ENC_360};
            home_tick_q <= home_sync_q[1] & ~home_sync_q[2];
            enc_tick_q  <= enc_sync_q[1] & ~enc_sync_q[2];
        end
    end

    // Home takes precedence; a coincident encoder tick is discarded.
    assign home_ev  = home_tick_q;
    assign enc_ev   = enc_tick_q & ~home_tick_q;
    assign boundary = enc_ev && (edge_cnt_q == EW'(SLICE_DIV - 1));
    assign slice_ev = home_ev | boundary;
    assign next_idx = home_ev ? '0 :
                      (slice_idx_q == 8'(SLICES - 1)) ? '0 : slice_idx_q + 8'd1;

    assign in_wait     = (state_q == CTRL_WAIT) || (state_q == GS_WAIT);
    assign in_req      = (state_q == CTRL_REQ) || (state_q == GS_REQ);
    assign wait_done   = in_wait && shift_done;
    assign wait_expire = in_wait && !shift_done && (wait_cnt_q == WW'(TIMEOUT - 1));

    always_comb begin
        edge_cnt_d   = edge_cnt_q;
        slice_idx_d  = slice_idx_q;
        slice_pend_d = slice_pend_q;
        pend_idx_d   = pend_idx_q;
        ctrl_pend_d  = ctrl_pend_q;
        gs_cnt_d     = gs_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;

        if (clr_flags) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end

        if (home_ev) begin
            edge_cnt_d  = '0;
            slice_idx_d = '0;
        end else if (enc_ev) begin
            if (boundary) begin
                edge_cnt_d  = '0;
                slice_idx_d = next_idx;
            end else begin
                edge_cnt_d = edge_cnt_q + EW'(1);
            end
        end

        // The GS_REQ clear comes first so a boundary in the same cycle
        // re-arms slice_pend without counting as an overrun.
        if (state_q == GS_REQ)
            slice_pend_d = 1'b0;
        if (slice_ev && enable) begin
            if (slice_pend_q && (state_q != GS_REQ))
                overrun_d = 1'b1;
            slice_pend_d = 1'b1;
            pend_idx_d   = next_idx;
        end

        if ((state_q == CTRL_WAIT) && shift_done)
            ctrl_pend_d = 1'b0;
        if ((state_q == GS_WAIT) && shift_done) begin
            if (gs_cnt_q == GW'(CTRL_REFRESH - 1)) begin
                gs_cnt_d    = '0;
                ctrl_pend_d = 1'b1;
            end else begin
                gs_cnt_d = gs_cnt_q + GW'(1);
            end
        end
        if (wait_expire) begin
            timeout_d   = 1'b1;
            ctrl_pend_d = 1'b1;
        end
        if (home_ev)
            ctrl_pend_d = 1'b1;

        if (in_req)
            wait_cnt_d = '0;
        else if (in_wait)
            wait_cnt_d = wait_cnt_q + WW'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (enable) state_d = ARMED;
            ARMED: begin
                if (!enable)           state_d = IDLE;
                else if (ctrl_pend_q)  state_d = CTRL_REQ;
                else if (slice_pend_q) state_d = GS_REQ;
            end
            CTRL_REQ:  state_d = CTRL_WAIT;
            GS_REQ:    state_d = GS_WAIT;
            CTRL_WAIT: if (wait_done || wait_expire) state_d = ARMED;
            GS_WAIT:   if (wait_done || wait_expire) state_d = ARMED;
            default:   state_d = IDLE;
        endcase
    end

    // Request outputs are registered, so shift_start appears in the first
    // WAIT cycle and sel/slice stay put until the next request.
    always_comb begin
        shift_start_d = 1'b0;
        shift_sel_d   = shift_sel_q;
        shift_slice_d = shift_slice_q;
        case (state_q)
            CTRL_REQ: begin
                shift_start_d = 1'b1;
                shift_sel_d   = 1'b1;
            end
            GS_REQ: begin
                shift_start_d = 1'b1;
                shift_sel_d   = 1'b0;
                shift_slice_d = pend_idx_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_10M or negedge nReset) begin
        if (!nReset) begin
            state_q       <= IDLE;
            edge_cnt_q    <= '0;
            slice_idx_q   <= '0;
            slice_pend_q  <= 1'b0;
            pend_idx_q    <= '0;
            ctrl_pend_q   <= 1'b1;
            gs_cnt_q      <= '0;
            wait_cnt_q    <= '0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            shift_start_q <= 1'b0;
            shift_sel_q   <= 1'b0;
            shift_slice_q <= '0;
        end else begin
            state_q       <= state_d;
            edge_cnt_q    <= edge_cnt_d;
            slice_idx_q   <= slice_idx_d;
            slice_pend_q  <= slice_pend_d;
            pend_idx_q    <= pend_idx_d;
            ctrl_pend_q   <= ctrl_pend_d;
            gs_cnt_q      <= gs_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
            shift_start_q <= shift_start_d;
            shift_sel_q   <= shift_sel_d;
            shift_slice_q <= shift_slice_d;
        end
    end

    assign shift_start = shift_start_q;
    assign shift_sel   = shift_sel_q;
    assign shift_slice = shift_slice_q;
    assign slice_idx   = slice_idx_q;
    assign busy        = in_wait;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_upload_scheduler.sv
// ---------------------------------------------------------------------------
// tb_upload_scheduler
//   Drives encoder pulses and acts as the shifter. A reference model of the
//   scheduling rules (one pending slice, newest wins, control first) pushes
//   expected uploads into a queue; the shifter/monitor process pops and
//   compares on every shift_start.
// ---------------------------------------------------------------------------
module tb_upload_scheduler;

    localparam int TIMEOUT = 4096;
    localparam int NSLICE  = 30;
    localparam int DIV     = 12;
    localparam int REFRESH = 10;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       home = 1'b0;
    logic       enc = 1'b0;
    logic       enable = 1'b0;
    logic       shift_done = 1'b0;
    logic       clr_flags = 1'b0;
    logic       shift_start, shift_sel, busy, overrun, timeout;
    logic [7:0] shift_slice, slice_idx;

    upload_scheduler #(
        .SLICES(NSLICE),
        .SLICE_DIV(DIV),
        .CTRL_REFRESH(REFRESH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_10M(clk),
        .nReset(nReset),
        .ENC_ABS_HOME(home),
        .ENC_360(enc),
        .enable(enable),
        .shift_done(shift_done),
        .clr_flags(clr_flags),
        .shift_start(shift_start),
        .shift_sel(shift_sel),
        .shift_slice(shift_slice),
        .slice_idx(slice_idx),
        .busy(busy),
        .overrun(overrun),
        .timeout(timeout)
    );

    always #50 clk = ~clk;

    typedef struct {
        bit       sel;
        bit [7:0] slice;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int m_edge, m_slice, m_pend_idx, m_gs;
    bit m_ctrl, m_spend, m_busy, m_over, m_to;
    bit slow = 1'b0;
    int withhold_n = 0;

    function automatic void check(string name, int act, int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_edge = 0; m_slice = 0; m_pend_idx = 0; m_gs = 0;
        m_ctrl = 1'b1; m_spend = 1'b0; m_busy = 1'b0;
        m_over = 1'b0; m_to = 1'b0;
    endfunction

    function automatic void dispatch();
        if (m_busy || !enable) return;
        if (m_ctrl) begin
            q.push_back('{sel: 1'b1, slice: 8'd0});
            m_busy = 1'b1;
        end else if (m_spend) begin
            q.push_back('{sel: 1'b0, slice: 8'(m_pend_idx)});
            m_spend = 1'b0;
            m_busy  = 1'b1;
        end
    endfunction

    function automatic void slice_event(int idx);
        if (!enable) return;
        if (m_spend) m_over = 1'b1;
        m_spend    = 1'b1;
        m_pend_idx = idx;
        dispatch();
    endfunction

    function automatic void upload_done(bit sel);
        m_busy = 1'b0;
        if (sel) m_ctrl = 1'b0;
        else begin
            m_gs++;
            if (m_gs == REFRESH) begin
                m_gs   = 0;
                m_ctrl = 1'b1;
            end
        end
        dispatch();
    endfunction

    function automatic void upload_timeout();
        m_busy = 1'b0;
        m_ctrl = 1'b1;
        m_to   = 1'b1;
        dispatch();
    endfunction

    // Shifter model + scoreboard monitor
    initial begin
        exp_t e;
        bit   sel_now, known;
        int   cyc, delay;
        forever begin
            @(negedge clk);
            if (nReset && shift_start) begin
                check("busy_at_start", busy, 1);
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_start: got sel=%0d slice=%0d expected no upload at %0t",
                             shift_sel, shift_slice, $time);
                    sel_now = shift_sel;
                    known   = 1'b0;
                end else begin
                    e = q.pop_front();
                    check("shift_sel", shift_sel, e.sel);
                    if (!e.sel) check("shift_slice", shift_slice, e.slice);
                    sel_now = e.sel;
                    known   = 1'b1;
                end
                if (withhold_n > 0) begin
                    withhold_n--;
                    cyc = 0;
                    while (nReset && !timeout && cyc < TIMEOUT + 100) begin
                        @(negedge clk);
                        cyc++;
                    end
                    if (nReset) begin
                        check("timeout_latency", cyc, TIMEOUT);
                        upload_timeout();
                    end
                end else begin
                    delay = slow ? 1600 : int'($urandom_range(2, 30));
                    cyc = 0;
                    while (nReset && cyc < delay) begin
                        @(negedge clk);
                        cyc++;
                    end
                    if (nReset) begin
                        shift_done = 1'b1;
                        @(negedge clk);
                        shift_done = 1'b0;
                        if (nReset) begin
                            check("busy_after_done", busy, 0);
                            if (known) upload_done(sel_now);
                        end
                    end
                end
            end
        end
    end

    task automatic enc_edge(input bit with_home, input int spacing);
        int hi;
        hi = spacing / 2;
        enc = 1'b1;
        if (with_home) home = 1'b1;
        if (with_home) begin
            m_edge  = 0;
            m_slice = 0;
            m_ctrl  = 1'b1;
            slice_event(0);
        end else begin
            m_edge++;
            if (m_edge == DIV) begin
                m_edge  = 0;
                m_slice = (m_slice + 1) % NSLICE;
                slice_event(m_slice);
            end
        end
        repeat (hi) @(negedge clk);
        enc  = 1'b0;
        home = 1'b0;
        repeat (spacing - hi) @(negedge clk);
        check("slice_idx", slice_idx, m_slice);
        check("overrun", overrun, m_over);
        check("timeout", timeout, m_to);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (m_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (m_busy) begin
            total++; bad++;
            $display("FAIL wait_idle: upload still outstanding after %0d cycles, expected done", bound);
        end
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        m_over = 1'b0;
        m_to   = 1'b0;
        @(negedge clk);
        check("clr_overrun", overrun, 0);
        check("clr_timeout", timeout, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_shift_start", shift_start, 0);
        check("rst_shift_sel", shift_sel, 0);
        check("rst_shift_slice", shift_slice, 0);
        check("rst_slice_idx", slice_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
    endtask

    initial begin
        model_reset();
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        nReset = 1'b1;
        dispatch();
        wait_idle(500);

        // Slow shifter, slices well apart: uploads of slices 1 and 2
        slow = 1'b1;
        repeat (24) enc_edge(1'b0, int'($urandom_range(150, 160)));
        wait_idle(3000);

        // Fast shifter, a full revolution with control refreshes
        slow = 1'b0;
        repeat (360) enc_edge(1'b0, int'($urandom_range(8, 20)));
        wait_idle(500);

        // Slow shifter, two boundaries during one grayscale wait
        slow = 1'b1;
        repeat (36) enc_edge(1'b0, int'($urandom_range(55, 65)));
        wait_idle(5000);
        check("overrun_seen", overrun, 1);
        clear_flags();

        // Home together with the 12th encoder edge
        slow = 1'b0;
        repeat (11) enc_edge(1'b0, int'($urandom_range(8, 20)));
        enc_edge(1'b1, 20);
        wait_idle(500);
        repeat (12) enc_edge(1'b0, int'($urandom_range(8, 20)));
        wait_idle(500);

        // Withheld shift_done
        withhold_n = 1;
        repeat (12) enc_edge(1'b0, 14);
        wait_idle(TIMEOUT + 1000);
        check("timeout_seen", timeout, 1);
        clear_flags();

        // Reset in the middle of a grayscale wait
        withhold_n = 1;
        repeat (12) enc_edge(1'b0, 14);
        repeat (200) @(negedge clk);
        check("busy_mid_wait", busy, 1);
        nReset = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        repeat (3) @(negedge clk);
        model_reset();
        withhold_n = 0;
        nReset = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_slice", slice_idx, 0);
        enable = 1'b1;
        dispatch();
        wait_idle(500);
        repeat (12) enc_edge(1'b0, int'($urandom_range(8, 20)));
        wait_idle(500);

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
